// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory-bus sequencer: FSM state
// encoding, the set of legal data byte enables and a legality check.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA_RD,
    DATA_WR,
    RESP
  } mem_seq_state_t;

  localparam logic [3:0] BE_BYTE0  = 4'b0001;
  localparam logic [3:0] BE_BYTE1  = 4'b0010;
  localparam logic [3:0] BE_BYTE2  = 4'b0100;
  localparam logic [3:0] BE_BYTE3  = 4'b1000;
  localparam logic [3:0] BE_HALF0  = 4'b0011;
  localparam logic [3:0] BE_HALF1  = 4'b1100;
  localparam logic [3:0] BE_WORD   = 4'b1111;
  localparam logic [3:0] BE_UPPER3 = 4'b1110;
  localparam logic [3:0] BE_LOWER3 = 4'b0111;

  // Byte, halfword, word, plus the 3-byte partials produced by LWL/LWR.
  function automatic logic be_is_legal(input logic [3:0] be);
    case (be)
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
      BE_HALF0, BE_HALF1, BE_WORD,
      BE_UPPER3, BE_LOWER3: be_is_legal = 1'b1;
      default:              be_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wait_timeout_counter.sv
// Counts consecutive stall cycles; expired fires in the stall cycle that
// brings the count to LIMIT, so the access can be aborted on that edge.
module wait_timeout_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = inc && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_sequencer.sv
// Multicycle Avalon-style bus master shared by instruction fetch and
// load/store accesses; data requests win over fetch when both are pending.
module mem_bus_sequencer
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        bus_error,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_seq_state_t state, next_state;

  logic        cap_data;
  logic        cap_err;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  logic in_access;
  logic complete;
  logic timeout;
  logic start;

  assign in_access = (state == FETCH) || (state == DATA_RD) || (state == DATA_WR);
  assign complete  = in_access && !avm_waitrequest;
  assign start     = (state == IDLE) && (next_state != IDLE);

  wait_timeout_counter #(
    .WIDTH (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_access),
    .inc     (in_access && avm_waitrequest),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (data_req) begin
          if (!be_is_legal(data_be)) begin
            next_state = RESP;
          end else if (data_we) begin
            next_state = DATA_WR;
          end else begin
            next_state = DATA_RD;
          end
        end else if (fetch_req) begin
          next_state = FETCH;
        end
      end
      FETCH, DATA_RD, DATA_WR: begin
        if (complete || timeout) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are frozen on the IDLE exit edge so the bus stays stable
  // regardless of what the requester does afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_data  <= 1'b0;
      cap_err   <= 1'b0;
      cap_addr  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
    end else if (start) begin
      cap_data  <= data_req;
      cap_err   <= data_req && !be_is_legal(data_be);
      cap_addr  <= (data_req ? data_addr : fetch_addr) & 32'hFFFF_FFFC;
      cap_be    <= data_req ? data_be : 4'b1111;
      cap_wdata <= (data_req && data_we) ? data_wdata : 32'h0;
    end else if (timeout) begin
      cap_err   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      if ((state == FETCH) && complete) begin
        fetch_rdata <= avm_readdata;
      end
      if ((state == DATA_RD) && complete) begin
        data_rdata <= avm_readdata;
      end
    end
  end

  // Outputs decode directly from registered state, so an async reset
  // removes strobes and done pulses in the same cycle.
  always_comb begin
    avm_read       = (state == FETCH) || (state == DATA_RD);
    avm_write      = (state == DATA_WR);
    avm_address    = in_access ? cap_addr  : 32'h0;
    avm_byteenable = in_access ? cap_be    : 4'h0;
    avm_writedata  = in_access ? cap_wdata : 32'h0;
    fetch_done     = (state == RESP) && !cap_data;
    data_done      = (state == RESP) && cap_data;
    bus_error      = (state == RESP) && cap_err;
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Self-checking bench for mem_bus_sequencer: directed scenarios followed by
// randomized accesses, checked against a transaction-level timing model.
module tb_mem_bus_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        bus_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_fetch_rdata;
  logic [31:0] exp_data_rdata;

  logic [3:0] legal_be [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0011, 4'b1100, 4'b1111, 4'b1110, 4'b0111};

  always #5 clk = ~clk;

  mem_bus_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_done      (fetch_done),
    .fetch_rdata     (fetch_rdata),
    .data_req        (data_req),
    .data_we         (data_we),
    .data_addr       (data_addr),
    .data_be         (data_be),
    .data_wdata      (data_wdata),
    .data_done       (data_done),
    .data_rdata      (data_rdata),
    .bus_error       (bus_error),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  function automatic bit be_legal(input logic [3:0] be);
    be_legal = 1'b0;
    foreach (legal_be[i]) if (legal_be[i] == be) be_legal = 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_read"},  32'(avm_read),   32'd0);
    checkOutput({tag, "_write"}, 32'(avm_write),  32'd0);
    checkOutput({tag, "_fdone"}, 32'(fetch_done), 32'd0);
    checkOutput({tag, "_ddone"}, 32'(data_done),  32'd0);
    checkOutput({tag, "_err"},   32'(bus_error),  32'd0);
  endtask

  // One complete transaction: the bench plays both requester and slave.
  // Cycle 0 is the cycle whose closing edge samples the request.
  task automatic applyStimulus(input bit is_data, input bit we,
                               input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input int waits,
                               input logic [31:0] rdata, input bit keep_fetch);
    bit legal, exp_err, exp_rd, exp_wr;
    int done_cyc, last_strobe;
    legal  = !is_data || be_legal(be);
    exp_rd = legal && !(is_data && we);
    exp_wr = legal && is_data && we;
    if (!legal) begin
      last_strobe = 0;  done_cyc = 1;         exp_err = 1'b1;
    end else if (waits >= T) begin
      last_strobe = T;  done_cyc = T + 1;     exp_err = 1'b1;
    end else begin
      last_strobe = waits + 1; done_cyc = waits + 2; exp_err = 1'b0;
    end

    if (is_data) begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_be = be; data_wdata = wdata;
      fetch_req = keep_fetch;
    end else begin
      fetch_req = 1'b1; fetch_addr = addr; data_req = 1'b0;
    end
    avm_waitrequest = 1'b1;
    avm_readdata    = $urandom;

    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(posedge clk); #1;
      avm_waitrequest = (c <= waits);
      avm_readdata    = (c <= waits) ? $urandom : rdata;
      checkOutput("avm_read",   32'(avm_read),   32'((c <= last_strobe) && exp_rd));
      checkOutput("avm_write",  32'(avm_write),  32'((c <= last_strobe) && exp_wr));
      if (c <= last_strobe) begin
        checkOutput("avm_address", avm_address, addr & 32'hFFFF_FFFC);
        checkOutput("avm_be", 32'(avm_byteenable), 32'(is_data ? be : 4'b1111));
        if (exp_wr) checkOutput("avm_wdata", avm_writedata, wdata);
      end
      checkOutput("data_done",  32'(data_done),  32'(is_data && (c == done_cyc)));
      checkOutput("fetch_done", 32'(fetch_done), 32'(!is_data && (c == done_cyc)));
      checkOutput("bus_error",  32'(bus_error),  32'((c == done_cyc) && exp_err));
      if (c == done_cyc) begin
        if (is_data) data_req = 1'b0;
        else         fetch_req = 1'b0;
      end else if (c < done_cyc) begin
        data_addr = $urandom; data_be = 4'($urandom); data_wdata = $urandom;
        data_we = 1'($urandom);
        if (is_data) fetch_addr = $urandom;
      end
    end

    if (legal && !exp_err) begin
      if (!is_data)  exp_fetch_rdata = rdata;
      else if (!we)  exp_data_rdata  = rdata;
    end
    checkOutput("fetch_rdata", fetch_rdata, exp_fetch_rdata);
    checkOutput("data_rdata",  data_rdata,  exp_data_rdata);
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_be = '0; data_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    exp_fetch_rdata = '0; exp_data_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_frdata", fetch_rdata, 32'h0);
    checkOutput("reset_drdata", data_rdata, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("post_reset");

    $display("[TB] fetch, zero wait");
    applyStimulus(1'b0, 1'b0, 32'hBFC0_0000, 4'b1111, 32'h0, 0, 32'h3C01_1234, 1'b0);

    $display("[TB] store byte lane 2, three wait cycles");
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 4'b0100, 32'h00AB_0000, 3, 32'h0, 1'b0);

    $display("[TB] simultaneous data load and fetch");
    applyStimulus(1'b1, 1'b0, 32'h0000_2004, 4'b1111, 32'h0, 1, 32'hCAFE_F00D, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'hBFC0_0004, 4'b1111, 32'h0, 0, 32'h2408_0001, 1'b0);

    $display("[TB] illegal byte enable");
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 4'b0101, 32'h0, 0, 32'h1111_1111, 1'b0);

    $display("[TB] waitrequest stuck, load and store timeout");
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 4'b0011, 32'h0, 10, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0404, 4'b1111, 32'h1234_5678, T, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0408, 4'b1110, 32'h0, T - 1, 32'h0BAD_C0DE, 1'b0);

    $display("[TB] reset during a stalled fetch");
    fetch_req = 1'b1; fetch_addr = 32'hBFC0_0100; avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_reset_read", 32'(avm_read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkIdleOutputs("mid_reset");
    checkOutput("mid_reset_addr", avm_address, 32'h0);
    checkOutput("mid_reset_frdata", fetch_rdata, 32'h0);
    checkOutput("mid_reset_drdata", data_rdata, 32'h0);
    exp_fetch_rdata = '0; exp_data_rdata = '0;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkIdleOutputs("after_reset");
    end
    applyStimulus(1'b0, 1'b0, 32'hBFC0_0200, 4'b1111, 32'h0, 2, 32'h0000_000C, 1'b0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [3:0] be;
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) be = 4'($urandom);
      else                           be = legal_be[$urandom_range(0, 8)];
      applyStimulus(kind != 0, kind == 2, $urandom, be, $urandom,
                    $urandom_range(0, 6), $urandom, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
